// File: rtl/bist_pkg.sv
// LBIST pattern-generator shared types, default Galois tap masks and LFSR step helper.
// Latency: n/a (declarations only).  Backpressure: n/a.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpg_state_t;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // Maximal-length right-shift Galois masks; zero for widths without a tabulated mask.
  function automatic logic [15:0] default_taps(input int width);
    case (width)
      4:       return 16'(TAPS_W4);
      8:       return 16'(TAPS_W8);
      16:      return TAPS_W16;
      default: return 16'd0;
    endcase
  endfunction

  // Right-shift Galois step; callers zero-extend and truncate to their width.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic [63:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 64'd0);
  endfunction

endpackage

// File: rtl/bist_tpg_if.sv
// Pattern-generator bundle: controller/CUT side (slave) and generator side (master).
// Latency: n/a (wires only).  Backpressure: run is the only stall input.
interface bist_tpg_if #(
  parameter int WIDTH    = 8,
  parameter int CNT_BITS = 16
);
  logic                tpg_rst;
  logic                run;
  logic [WIDTH-1:0]    pattern;
  logic                pattern_valid;
  logic [CNT_BITS-1:0] pattern_idx;
  logic                busy;
  logic                tpg_end;

  modport master (
    input  tpg_rst, run,
    output pattern, pattern_valid, pattern_idx, busy, tpg_end
  );

  modport slave (
    output tpg_rst, run,
    input  pattern, pattern_valid, pattern_idx, busy, tpg_end
  );
endinterface

// File: rtl/lfsr_galois.sv
// Right-shift Galois LFSR with synchronous seed load; BIST_TPG_EXHAUST_EN inserts the all-zero state.
// Latency: state updates on the edge after load/step.  Backpressure: holds when step is low.
module lfsr_galois
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = WIDTH'(lfsr_next(64'(state), 64'(TAPS)));
`ifdef BIST_TPG_EXHAUST_EN
    // Splice 0 between 1 and TAPS so the cycle covers all 2^WIDTH values.
    if (state == WIDTH'(1)) begin
      nxt = '0;
    end else if (state == '0) begin
      nxt = TAPS;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/bist_tpg.sv
// LBIST test pattern generator: one LFSR pattern per run cycle, tpg_end pulse after NUM_PATTERNS.
// Latency: all outputs registered, first pattern one edge after run.  Backpressure: run=0 stalls.
// Option: BIST_TPG_EXHAUST_EN adds the zero state for an exhaustive 2^WIDTH sequence.
module bist_tpg
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] SEED         = 8'h01,
  parameter int               NUM_PATTERNS = 255,
  parameter int               CNT_BITS     = 16
) (
  input logic        clk,
  input logic        rst_n,
  bist_tpg_if.master bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_PATTERNS - 1);

  if (WIDTH < 3 || WIDTH > 64) begin : g_width_chk
    $error("bist_tpg: WIDTH must be in 3..64");
  end
  if (!TAPS[WIDTH-1]) begin : g_taps_chk
    $error("bist_tpg: TAPS MSB must be set");
  end
  if (SEED == '0) begin : g_seed_chk
    $error("bist_tpg: SEED must be nonzero");
  end
  if (CNT_BITS < 1 || CNT_BITS > 62 || NUM_PATTERNS < 1 ||
      longint'(NUM_PATTERNS) > (longint'(1) << CNT_BITS) - 1) begin : g_np_chk
    $error("bist_tpg: NUM_PATTERNS must be in 1..2^CNT_BITS-1");
  end
`ifdef BIST_TPG_EXHAUST_EN
  if (longint'(NUM_PATTERNS) > (longint'(1) << WIDTH)) begin : g_exh_chk
    $error("bist_tpg: NUM_PATTERNS exceeds 2^WIDTH");
  end
`endif

  logic [1:0]          state_q;
  logic [CNT_BITS-1:0] idx_q;
  logic                valid_q;
  logic                busy_q;
  logic                end_q;
  logic [WIDTH-1:0]    lfsr_q;
  logic                lfsr_load;
  logic                lfsr_step;

  // IDLE keeps reloading so the first RUN cycle always presents SEED.
  assign lfsr_load = bus.tpg_rst || (state_q == S_IDLE);
  assign lfsr_step = (state_q == S_RUN) && bus.run && (idx_q != LAST_IDX);

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
    end else if (bus.tpg_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.run) begin
            valid_q <= 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b1;
          end else begin
            idx_q   <= idx_q + CNT_BITS'(1);
            valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern       = lfsr_q;
  assign bus.pattern_valid = valid_q;
  assign bus.pattern_idx   = idx_q;
  assign bus.busy          = busy_q;
  assign bus.tpg_end       = end_q;

endmodule

// File: tb/tb_bist_tpg.sv
// Bench for bist_tpg (WIDTH=4, TAPS=C): cycle model + directed checks; also a NUM_PATTERNS=1 instance.
`timescale 1ns/1ps
module tb_bist_tpg;
  import bist_pkg::*;

`ifdef BIST_TPG_EXHAUST_EN
  localparam int NP = 16;
  localparam logic [3:0] LIT [16] = '{4'h1, 4'h0, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5,
                                      4'hE, 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
`else
  localparam int NP = 15;
  localparam logic [3:0] LIT [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5,
                                      4'hE, 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_tpg_if #(.WIDTH(4), .CNT_BITS(16)) bus ();
  bist_tpg_if #(.WIDTH(4), .CNT_BITS(16)) bus1 ();

  bist_tpg #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .NUM_PATTERNS(NP), .CNT_BITS(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  bist_tpg #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .NUM_PATTERNS(1), .CNT_BITS(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected pattern per index, built from the step rule alone.
  int seq [NP];
  initial begin
    int s;
    s = 1;
    for (int i = 0; i < NP; i++) begin
      seq[i] = s;
`ifdef BIST_TPG_EXHAUST_EN
      if (s == 1)      s = 0;
      else if (s == 0) s = 'hC;
      else             s = (s / 2) ^ ((s % 2) ? 'hC : 0);
`else
      s = (s / 2) ^ ((s % 2) ? 'hC : 0);
`endif
    end
  end

  // Cycle model: phase 0=idle, 1=running, 2=finished.
  int m_ph, m_idx;
  bit m_vld, m_end;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_idx = 0; m_vld = 0; m_end = 0;
    end else begin
      m_end = 0;
      if (bus.tpg_rst) begin
        m_ph = 0; m_idx = 0; m_vld = 0;
      end else if (m_ph == 0) begin
        if (bus.run) begin m_ph = 1; m_idx = 0; m_vld = 1; end
      end else if (m_ph == 1) begin
        if (!bus.run) m_vld = 0;
        else if (m_idx == NP - 1) begin m_ph = 2; m_vld = 0; m_end = 1; end
        else begin m_idx++; m_vld = 1; end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_pattern", 32'(bus.pattern), 32'(seq[m_idx]));
    chk("cyc_valid",   32'(bus.pattern_valid), 32'(m_vld));
    chk("cyc_idx",     32'(bus.pattern_idx), 32'(m_idx));
    chk("cyc_busy",    32'(bus.busy), 32'(m_ph == 1));
    chk("cyc_end",     32'(bus.tpg_end), 32'(m_end));
  end

  bit collecting = 0;
  logic [3:0] seen [$];
  always @(negedge clk) if (collecting && bus.pattern_valid) seen.push_back(bus.pattern);

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dup;
    bus.run = 0; bus.tpg_rst = 0; bus1.run = 0; bus1.tpg_rst = 0;
    #1;
    for (int i = 0; i < NP; i++) chk("model_seq", 32'(seq[i]), 32'(LIT[i]));
    tick(); tick();
    chk("rst_pattern", 32'(bus.pattern), 32'h1);
    chk("rst_valid", 32'(bus.pattern_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1;

    // Full run with run held high.
    bus.run = 1; collecting = 1;
    tick();
    chk("first_pattern", 32'(bus.pattern), 32'h1);
    chk("first_busy", 32'(bus.busy), 1);
    repeat (NP - 1) tick();
    chk("last_idx", 32'(bus.pattern_idx), 32'(NP - 1));
    chk("last_pattern", 32'(bus.pattern), 32'(LIT[NP-1]));
    tick();
    chk("end_pulse", 32'(bus.tpg_end), 1);
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_hold_idx", 32'(bus.pattern_idx), 32'(NP - 1));
    tick();
    chk("end_single", 32'(bus.tpg_end), 0);
    repeat (3) tick();
    chk("done_no_restart", 32'(bus.pattern_valid), 0);
    collecting = 0;
    chk("seen_count", 32'(seen.size()), 32'(NP));
    dup = 0;
    for (int i = 0; i < seen.size(); i++)
      for (int j = i + 1; j < seen.size(); j++)
        if (seen[i] == seen[j]) dup++;
    chk("seen_distinct", 32'(dup), 0);
    for (int i = 0; i < seen.size() && i < NP; i++) chk("seen_value", 32'(seen[i]), 32'(LIT[i]));

    // Restart, then stall for 3 cycles after idx 5.
    bus.tpg_rst = 1; tick(); bus.tpg_rst = 0;
    chk("trst_pattern", 32'(bus.pattern), 32'h1);
    tick();
    repeat (5) tick();
    chk("pre_stall_idx", 32'(bus.pattern_idx), 5);
    bus.run = 0;
    repeat (3) begin
      tick();
      chk("stall_valid", 32'(bus.pattern_valid), 0);
      chk("stall_pattern", 32'(bus.pattern), 32'(LIT[5]));
      chk("stall_busy", 32'(bus.busy), 1);
    end
    bus.run = 1; tick();
    chk("resume_idx", 32'(bus.pattern_idx), 6);
    chk("resume_pattern", 32'(bus.pattern), 32'(LIT[6]));

    // tpg_rst at idx 7.
    tick();
    bus.tpg_rst = 1; tick(); bus.tpg_rst = 0;
    chk("mid_rst_idx", 32'(bus.pattern_idx), 0);
    chk("mid_rst_end", 32'(bus.tpg_end), 0);
    tick(); tick();
    chk("restart_idx1", 32'(bus.pattern), 32'(LIT[1]));

    // tpg_rst coinciding with the final step.
    repeat (NP - 2) tick();
    chk("final_idx", 32'(bus.pattern_idx), 32'(NP - 1));
    bus.tpg_rst = 1; tick(); bus.tpg_rst = 0;
    chk("final_rst_end", 32'(bus.tpg_end), 0);
    chk("final_rst_busy", 32'(bus.busy), 0);
    tick();
    chk("final_rst_no_end", 32'(bus.tpg_end), 0);

    // Asynchronous reset between edges mid-run.
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst_pattern", 32'(bus.pattern), 32'h1);
    chk("arst_idx", 32'(bus.pattern_idx), 0);
    chk("arst_valid", 32'(bus.pattern_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_end", 32'(bus.tpg_end), 0);
    bus.run = 0;
    tick();
    rst_n = 1;

    // NUM_PATTERNS=1 instance.
    bus1.run = 1; tick();
    chk("np1_valid", 32'(bus1.pattern_valid), 1);
    chk("np1_pattern", 32'(bus1.pattern), 32'h1);
    tick();
    chk("np1_end", 32'(bus1.tpg_end), 1);
    chk("np1_busy", 32'(bus1.busy), 0);
    tick();
    chk("np1_end_single", 32'(bus1.tpg_end), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
